// File: rtl/mat_mult_seq.sv
// rtl/mat_mult_seq.sv - sequencer for an NxN signed matrix multiply C = A x B over three RAMs
// One operand pair is issued per non-stalled cycle; one C element is written per N issues.
module mat_mult_seq #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(N),
  parameter int ADDR_W = 2*$clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_rdata,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr,
  output logic [ACC_W-1:0]  c_wdata
);
  localparam int LW = $clog2(N);
  localparam int SW = 3*LW;
  localparam int PW = 2*DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state;
  logic [SW-1:0]           step;      // {i, j, k} of the next step to issue
  logic [LW-1:0]           s_i, s_j, s_k;
  logic                    d_valid;
  logic [LW-1:0]           d_i, d_j, d_k;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [PW-1:0]    prod;

  assign s_i = step[SW-1:2*LW];
  assign s_j = step[2*LW-1:LW];
  assign s_k = step[LW-1:0];

  always_comb begin
    prod = $signed(a_rdata) * $signed(b_rdata);
    sum  = (d_k == '0 ? '0 : acc) + {{(ACC_W-PW){prod[PW-1]}}, prod};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      step    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_rd_en <= 1'b0;
      b_rd_en <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      c_we    <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
      d_valid <= 1'b0;
      d_i     <= '0;
      d_j     <= '0;
      d_k     <= '0;
      acc     <= '0;
    end else begin
      a_rd_en <= 1'b0;
      b_rd_en <= 1'b0;
      c_we    <= 1'b0;
      done    <= 1'b0;

      // Data stage: the read issued last cycle has its RAM data on the bus now.
      d_valid <= a_rd_en;
      d_i     <= a_addr[2*LW-1:LW];
      d_k     <= a_addr[LW-1:0];
      d_j     <= b_addr[LW-1:0];
      if (d_valid) begin
        acc <= sum;
        if (&d_k) begin
          c_we    <= 1'b1;
          c_addr  <= {d_i, d_j};
          c_wdata <= sum;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            a_rd_en <= 1'b1;
            b_rd_en <= 1'b1;
            a_addr  <= '0;
            b_addr  <= '0;
            step    <= SW'(1);
          end
        end
        RUN: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            d_valid <= 1'b0;
            c_we    <= 1'b0;
          end else if (!stall) begin
            a_rd_en <= 1'b1;
            b_rd_en <= 1'b1;
            a_addr  <= {s_i, s_k};
            b_addr  <= {s_k, s_j};
            step    <= step + SW'(1);
            if (&step) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            d_valid <= 1'b0;
            c_we    <= 1'b0;
          end else if (c_we) begin
            // Only the final element is written while draining.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mat_mult_seq.sv
// tb/tb_mat_mult_seq.sv - directed bench for mat_mult_seq with behavioural A/B/C RAMs
module tb_mat_mult_seq;
  localparam int N = 8, DATA_W = 8, ACC_W = 19, ADDR_W = 6, NE = 64, TMAX = 1100;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, stall = 1'b0;
  logic busy, done, a_rd_en, b_rd_en, c_we;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [ACC_W-1:0]  c_wdata;

  logic signed [DATA_W-1:0] a_mem [NE];
  logic signed [DATA_W-1:0] b_mem [NE];
  int c_mem [NE];
  int exp_c [NE];
  bit c_clr = 1'b0;

  int cyc = 0, t0 = 0, stop_rel = 0, mon_r = 0;
  bit mon_en = 1'b0;
  bit busy_tr [TMAX], we_tr [TMAX], done_tr [TMAX], rd_tr [TMAX], ab_tr [TMAX], stall_tr [TMAX];
  bit stall_sched [TMAX];
  int first_we, last_we, n_we, consec, busy_cnt, n_done, done_cyc, rd_bad, ab_bad, late_rd;
  int tests_run = 0, fails = 0;

  mat_mult_seq #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stall(stall),
    .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
    .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (a_rd_en) a_rdata <= a_mem[a_addr];
    if (b_rd_en) b_rdata <= b_mem[b_addr];
  end

  always @(posedge clk) begin
    if (c_clr) begin
      for (int e = 0; e < NE; e++) c_mem[e] <= -999999;
    end else if (c_we) begin
      c_mem[c_addr] <= int'($signed(c_wdata));
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      mon_r = cyc - t0;
      if (mon_r >= 0 && mon_r < TMAX) begin
        busy_tr[mon_r]  = busy;
        we_tr[mon_r]    = c_we;
        done_tr[mon_r]  = done;
        rd_tr[mon_r]    = a_rd_en;
        ab_tr[mon_r]    = (a_rd_en != b_rd_en);
        stall_tr[mon_r] = stall;
      end
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint outs_vec();
    return longint'({busy, done, a_rd_en, b_rd_en, c_we, a_addr, b_addr, c_addr, c_wdata});
  endfunction

  function automatic int c_bad();
    int n = 0;
    for (int e = 0; e < NE; e++) if (c_mem[e] != exp_c[e]) n++;
    return n;
  endfunction

  task automatic model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_c[i*N+j] = 0;
        for (int k = 0; k < N; k++)
          exp_c[i*N+j] += int'(a_mem[i*N+k]) * int'(b_mem[k*N+j]);
      end
  endtask

  task automatic fill_random();
    for (int e = 0; e < NE; e++) begin
      a_mem[e] = DATA_W'($urandom_range(0, 255));
      b_mem[e] = DATA_W'($urandom_range(0, 255));
    end
    model();
  endtask

  task automatic analyze();
    first_we = -1; last_we = -1; n_we = 0; consec = 0; busy_cnt = 0;
    n_done = 0; done_cyc = -1; rd_bad = 0; ab_bad = 0; late_rd = -1;
    for (int r = 0; r <= stop_rel; r++) begin
      if (we_tr[r]) begin
        if (first_we < 0) first_we = r;
        last_we = r;
        n_we++;
        if (r > 0 && we_tr[r-1]) consec++;
      end
      if (busy_tr[r] && r <= 515) busy_cnt++;
      if (done_tr[r]) begin
        n_done++;
        if (done_cyc < 0) done_cyc = r;
      end
      if (r > 0 && stall_tr[r-1] && rd_tr[r]) rd_bad++;
      if (ab_tr[r]) ab_bad++;
      if (r >= 516 && rd_tr[r] && late_rd < 0) late_rd = r;
    end
  endtask

  // Cycle 0 is the cycle in which start is first high.
  task automatic run_op(input int stop, input int hold_until, input int abort_at);
    @(posedge clk); #1 c_clr = 1'b1;
    @(posedge clk); #1 c_clr = 1'b0;
    stop_rel = stop;
    start    = 1'b1;
    stall    = stall_sched[0];
    t0       = cyc;
    mon_en   = 1'b1;
    for (int r = 1; r <= stop; r++) begin
      @(posedge clk); #1;
      start = (r <= hold_until);
      stall = stall_sched[r];
      abort = (r == abort_at);
    end
    @(negedge clk); #1;
    mon_en = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;
    analyze();
  endtask

  initial begin
    for (int r = 0; r < TMAX; r++) stall_sched[r] = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outs", outs_vec(), 0);
    rst_n = 1'b1;

    for (int e = 0; e < NE; e++) begin
      a_mem[e] = (e / N == e % N) ? 8'sd1 : 8'sd0;
      b_mem[e] = DATA_W'(e);
      exp_c[e] = e;
    end
    run_op(520, 0, -1);
    check("id_c", c_bad(), 0);
    check("id_nwe", n_we, 64);
    check("id_first_we", first_we, 10);
    check("id_last_we", last_we, 514);
    check("id_done_cyc", done_cyc, 515);
    check("id_ndone", n_done, 1);
    check("id_busy_cnt", busy_cnt, 514);
    check("id_consec_we", consec, 0);
    check("id_rd_ab", ab_bad, 0);

    for (int e = 0; e < NE; e++) begin
      a_mem[e] = -8'sd128; b_mem[e] = -8'sd128; exp_c[e] = 131072;
    end
    run_op(520, 0, -1);
    check("sat_neg_c", c_bad(), 0);
    check("sat_neg_nwe", n_we, 64);
    for (int e = 0; e < NE; e++) begin
      b_mem[e] = 8'sd127; exp_c[e] = -130048;
    end
    run_op(520, 0, -1);
    check("sat_mix_c", c_bad(), 0);
    check("sat_mix_nwe", n_we, 64);

    fill_random();
    stall_sched[50] = 1'b1; stall_sched[51] = 1'b1; stall_sched[300] = 1'b1; stall_sched[516] = 1'b1;
    run_op(525, 0, -1);
    for (int r = 0; r < TMAX; r++) stall_sched[r] = 1'b0;
    check("stall_c", c_bad(), 0);
    check("stall_done_cyc", done_cyc, 518);
    check("stall_rd_bad", rd_bad, 0);
    check("stall_first_we", first_we, 10);
    check("stall_last_we", last_we, 517);

    run_op(110, 0, 100);
    check("abort_busy100", busy_tr[100], 1);
    check("abort_busy101", busy_tr[101], 0);
    check("abort_last_we", last_we, 98);
    check("abort_nwe", n_we, 12);
    check("abort_ndone", n_done, 0);
    fill_random();
    run_op(520, 0, -1);
    check("post_abort_c", c_bad(), 0);
    check("post_abort_done", done_cyc, 515);

    run_op(1035, 600, -1);
    check("b2b_late_rd", late_rd, 517);
    check("b2b_busy_cnt", busy_cnt, 514);
    check("b2b_ndone", n_done, 2);
    check("b2b_nwe", n_we, 128);
    check("b2b_c", c_bad(), 0);

    fill_random();
    run_op(200, 0, -1);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1 check("rst_async_outs", outs_vec(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(520, 0, -1);
    check("post_rst_c", c_bad(), 0);
    check("post_rst_nwe", n_we, 64);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/mat_mult_seq.md
# mat_mult_seq

Sequencer for the 8x8 matrix multiply datapath. Drives the A and B operand memories (one-cycle read latency), accumulates products internally, and writes each result element to the C memory. Computes C = A x B, row-major, one multiply-accumulate per cycle. Sits between the system control (start/done) and the three matrix RAMs.

## Interface
Parameters:
- N, 8: matrix dimension; must be a power of two, at least 2.
- DATA_W, 8: A/B element width, signed two's complement.
- ACC_W, 2*DATA_W+$clog2(N) (19): accumulator and C element width, signed.
- ADDR_W, 2*$clog2(N) (6): flat element address width, addr = row*N + col.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: begin a multiply; sampled only in IDLE.
- abort, input, 1: cancel the operation in progress.
- stall, input, 1: freeze operand issue.
- busy, output, 1: operation in progress.
- done, output, 1: one-cycle pulse after the last C write.
- a_rd_en, output, 1: A read strobe.
- a_addr, output, ADDR_W: A address, i*N+k.
- a_rdata, input, DATA_W: A data, valid the cycle after a_rd_en.
- b_rd_en, output, 1: B read strobe; always equal to a_rd_en.
- b_addr, output, ADDR_W: B address, k*N+j.
- b_rdata, input, DATA_W: B data, valid the cycle after b_rd_en.
- c_we, output, 1: C write strobe.
- c_addr, output, ADDR_W: C address, i*N+j.
- c_wdata, output, ACC_W: C element value.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start=1. Counters i, j, k reset to 0.
- RUN issues one step per non-stalled cycle in the order k fastest, then j, then i, for N^3 = 512 steps.
- RUN -> DRAIN on the edge that issues step (N-1, N-1, N-1).
- DRAIN -> DONE after the final write is registered.
- DONE -> IDLE after one cycle.
- Data stage, one cycle after a read issue: acc <= (k_d==0 ? 0 : acc) + sext(a_rdata)*sext(b_rdata). k_d is the k value of that issue.
- When k_d==N-1, the write is registered on the same edge: c_we <= 1, c_addr <= i_d*N+j_d, c_wdata <= the new sum.
- Arithmetic is full-precision signed. ACC_W cannot overflow.
- stall=1 in RUN: a_rd_en/b_rd_en = 0 and i, j, k hold. The data stage still consumes the read issued in the previous cycle. Stall in any other state has no effect.
- start while busy or in DONE is ignored.
- abort=1 in RUN or DRAIN: next state is IDLE, and all strobes plus busy deassert on the next edge. Any pending or in-flight write is suppressed and done does not pulse. Elements already written stay in C. abort in IDLE or DONE is ignored.
- rst_n low at any time: state IDLE and acc 0 immediately. All outputs go to 0: busy, done, a_rd_en, b_rd_en, c_we, a_addr, b_addr, c_addr, c_wdata.

## Timing
- All outputs are registered.
- With start high in cycle 0 and no stalls:
  - Step s is issued in cycle 1+s; busy is high in cycles 1..514.
  - The first C write (element 0, index 0) is in cycle 10.
  - Element e is written in cycle 10+8e; the last one is in cycle 514.
  - done is high in cycle 515 only, busy is low from 515, and a new start is accepted from cycle 516.
- Each stalled cycle delays every later event by exactly one cycle.
- c_we is high for one cycle per element and never on two consecutive cycles (N>=2).
- rd_en and c_we can be high in the same cycle.
- The sequencer has no back-pressure from C: the C write always completes in one cycle.

## Test plan
- Identity test: A=I, B[r][c]=r*8+c, pulse start -> 64 writes with C[e]=e; first write in cycle 10, done in cycle 515 only; busy high for exactly 514 cycles.
- Saturation test: all A=-128 and all B=-128 -> every C=131072. Then A=-128 and B=127 -> every C=-130048. Checks sign extension and ACC_W.
- Stall test: random A/B, stall on 3 cycles during RUN and 1 cycle after the last issue -> C matches the reference model; done in cycle 518; no rd_en during stalled RUN cycles.
- Abort test: abort in cycle 100 -> busy low in cycle 101, no c_we after cycle 100, no done. A following start gives a correct full result.
- Back-to-back starts: start held high continuously -> the second operation's first rd_en is in cycle 517; start is ignored while busy.
- Reset mid-operation: rst_n low in cycle 200 -> all outputs 0 asynchronously. After release, a start gives a correct full result.
